// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO burst reader.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF    = 16;
  localparam int FIFO_LENWIDTH_DEF = 5;

  localparam logic [15:0] WORD_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// Control, FIFO-side and output-side signals of the burst reader.
// slave: the reader itself; master: whoever drives start/FIFO/ready.
interface fifo_reader_if #(
  parameter int WIDTH    = fifo_pkg::FIFO_WIDTH_DEF,
  parameter int LENWIDTH = fifo_pkg::FIFO_LENWIDTH_DEF
);

  logic                start;
  logic [LENWIDTH-1:0] burst_len;
  logic                busy;
  logic                done;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [WIDTH-1:0]    fifo_data;
  logic [WIDTH-1:0]    dout;
  logic                dout_valid;
  logic                dout_ready;

  modport slave (
    input  start, burst_len, fifo_empty, fifo_data, dout_ready,
    output busy, done, fifo_pop, dout, dout_valid
  );

  modport master (
    output start, burst_len, fifo_empty, fifo_data, dout_ready,
    input  busy, done, fifo_pop, dout, dout_valid
  );

endinterface

// File: rtl/fifo_reader.sv
// Drains burst_len words from a FIFO, one word per three cycles, into a held output register.
// Optional FIFO_READER_STATS_EN adds a saturating word_count of accepted output words.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int LENWIDTH = FIFO_LENWIDTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
`ifdef FIFO_READER_STATS_EN
  output logic [15:0]   word_count,
`endif
  fifo_reader_if.slave  bus
);

  rd_state_e           state_q;
  logic [LENWIDTH-1:0] remaining_q;
  logic [LENWIDTH-1:0] remaining_d;
  logic [WIDTH-1:0]    dout_q;
  logic                dout_valid_q;
  logic                done_q;
  logic                busy_q;
  logic                handshake;

  assign handshake   = dout_valid_q && bus.dout_ready;
  // Never wraps: remaining is only loaded with non-zero lengths and leaves HOLD at 1.
  assign remaining_d = remaining_q - LENWIDTH'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.burst_len != '0) begin
              remaining_q <= bus.burst_len;
              busy_q      <= 1'b1;
              state_q     <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!bus.fifo_empty) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          dout_q       <= bus.fifo_data;
          dout_valid_q <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (handshake) begin
            remaining_q  <= remaining_d;
            dout_valid_q <= 1'b0;
            if (remaining_q == LENWIDTH'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The pop is combinational so the FIFO advances in the same cycle it is seen non-empty.
  assign bus.fifo_pop   = (state_q == ISSUE) && !bus.fifo_empty;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

`ifdef FIFO_READER_STATS_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      word_count_q <= '0;
    end else if (handshake && (word_count_q != WORD_COUNT_MAX)) begin
      word_count_q <= word_count_q + 16'd1;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: FIFO model feeds words, expected words are queued at push
// time and compared on every output handshake. FIFO_READER_STATS_EN also checks word_count.
module tb_fifo_reader;

  localparam int WIDTH    = 16;
  localparam int LENWIDTH = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fifo_reader_if #(.WIDTH(WIDTH), .LENWIDTH(LENWIDTH)) bus ();

`ifdef FIFO_READER_STATS_EN
  logic [15:0] word_count;
`endif

  fifo_reader #(
    .WIDTH    (WIDTH),
    .LENWIDTH (LENWIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef FIFO_READER_STATS_EN
    .word_count (word_count),
`endif
    .bus        (bus.slave)
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               fifo_cnt    = 0;
  logic             force_empty = 1'b0;
  logic             pop_pending = 1'b0;

  int n_checks    = 0;
  int n_fail      = 0;
  int done_cnt    = 0;
  int pop_cnt     = 0;
  int busy_cycles = 0;

  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [WIDTH-1:0] prev_dout  = '0;

  assign bus.fifo_empty = force_empty | (fifo_cnt == 0);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: a pop seen during a cycle makes the next word appear just after the following edge.
  always @(posedge clock) begin
    #1;
    if (pop_pending && fifo_q.size() != 0) begin
      bus.fifo_data = fifo_q.pop_front();
      fifo_cnt--;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      pop_pending = bus.fifo_pop;
      if (bus.fifo_pop) begin
        pop_cnt++;
        check_eq("pop_nonempty", 32'(bus.fifo_empty), 32'd0);
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_cnt++;
        check_eq("busy_at_done", 32'(bus.busy), 32'd0);
      end
      if (prev_valid && !prev_ready) begin
        check_eq("hold_valid", 32'(bus.dout_valid), 32'd1);
        check_eq("hold_dout", 32'(bus.dout), 32'(prev_dout));
      end
      if (bus.dout_valid && bus.dout_ready) begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
      prev_valid = bus.dout_valid;
      prev_ready = bus.dout_ready;
      prev_dout  = bus.dout;
    end else begin
      pop_pending = 1'b0;
      prev_valid  = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_cnt++;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.burst_len = '0;
    fifo_q.delete();
    exp_q.delete();
    fifo_cnt = 0;
    step();
    step();
    @(negedge clock);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_pop", 32'(bus.fifo_pop), 32'd0);
    check_eq("rst_valid", 32'(bus.dout_valid), 32'd0);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic start_burst(input int len);
    step();
    bus.burst_len = LENWIDTH'(len);
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.done) break;
    end
    check_eq(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic wait_signal_pop(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.fifo_pop) break;
    end
    check_eq(tag, 32'(bus.fifo_pop), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, b0;
    bus.start      = 1'b0;
    bus.burst_len  = '0;
    bus.dout_ready = 1'b0;
    bus.fifo_data  = '0;

    do_reset();

    // Scenario 1: three-word burst at full rate
    d0 = done_cnt; p0 = pop_cnt; b0 = busy_cycles;
    push_word(16'h00A1); push_word(16'h00B2); push_word(16'h00C3);
    bus.dout_ready = 1'b1;
    start_burst(3);
    wait_done("s1_done", 40);
    step();
    check_eq("s1_pops", 32'(pop_cnt - p0), 32'd3);
    check_eq("s1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("s1_busy_cycles", 32'(busy_cycles - b0), 32'd9);
    check_eq("s1_sb_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check_eq("s1_busy_after", 32'(bus.busy), 32'd0);

    // Scenario 2: FIFO empty for five cycles after start
    p0 = pop_cnt;
    force_empty = 1'b1;
    push_word(16'h1111); push_word(16'h2222);
    start_burst(2);
    repeat (5) begin
      @(negedge clock);
      check_eq("s2_no_pop", 32'(bus.fifo_pop), 32'd0);
      check_eq("s2_busy", 32'(bus.busy), 32'd1);
    end
    step();
    force_empty = 1'b0;
    @(negedge clock);
    check_eq("s2_first_pop", 32'(bus.fifo_pop), 32'd1);
    wait_done("s2_done", 40);
    step();
    check_eq("s2_pops", 32'(pop_cnt - p0), 32'd2);
    check_eq("s2_sb_drained", 32'(exp_q.size()), 32'd0);

    // Scenario 3: downstream stalls in HOLD
    bus.dout_ready = 1'b0;
    push_word(16'h00D4);
    start_burst(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.dout_valid) break;
    end
    check_eq("s3_valid", 32'(bus.dout_valid), 32'd1);
    check_eq("s3_dout", 32'(bus.dout), 32'h00D4);
    repeat (3) begin
      @(negedge clock);
      check_eq("s3_stall_valid", 32'(bus.dout_valid), 32'd1);
      check_eq("s3_stall_dout", 32'(bus.dout), 32'h00D4);
      check_eq("s3_stall_done", 32'(bus.done), 32'd0);
    end
    step();
    bus.dout_ready = 1'b1;
    @(negedge clock);
    check_eq("s3_hs_no_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    check_eq("s3_done", 32'(bus.done), 32'd1);
    step();
    check_eq("s3_sb_drained", 32'(exp_q.size()), 32'd0);

    // Scenario 4: zero-length request
    p0 = pop_cnt;
    start_burst(0);
    @(negedge clock);
    check_eq("s4_done", 32'(bus.done), 32'd1);
    check_eq("s4_busy", 32'(bus.busy), 32'd0);
    step();
    @(negedge clock);
    check_eq("s4_done_once", 32'(bus.done), 32'd0);
    check_eq("s4_busy_after", 32'(bus.busy), 32'd0);
    step();
    check_eq("s4_no_pop", 32'(pop_cnt - p0), 32'd0);

    // Scenario 5: reset while waiting on FIFO data
    push_word(16'h0A00); push_word(16'h0A01); push_word(16'h0A02); push_word(16'h0A03);
    start_burst(4);
    wait_signal_pop("s5_pop", 10);
    step();
    d0 = done_cnt;
    do_reset();
    repeat (4) step();
    check_eq("s5_no_done", 32'(done_cnt - d0), 32'd0);
    p0 = pop_cnt;
    push_word(16'h5A5A); push_word(16'hA5A5);
    start_burst(2);
    wait_done("s5_restart_done", 40);
    step();
    check_eq("s5_restart_pops", 32'(pop_cnt - p0), 32'd2);
    check_eq("s5_sb_drained", 32'(exp_q.size()), 32'd0);

    // Scenario 6: start while busy is ignored, then 3 + 5 words
    do_reset();
    d0 = done_cnt; p0 = pop_cnt;
    push_word(16'h0031); push_word(16'h0032); push_word(16'h0033);
    start_burst(3);
    step();
    bus.burst_len = LENWIDTH'(5);
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    wait_done("s6_first_done", 60);
    step();
    check_eq("s6_first_pops", 32'(pop_cnt - p0), 32'd3);
    check_eq("s6_first_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("s6_idle", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 5; i++) push_word(WIDTH'(16'h0060 + i));
    start_burst(5);
    wait_done("s6_second_done", 60);
    step();
    check_eq("s6_total_pops", 32'(pop_cnt - p0), 32'd8);
    check_eq("s6_sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_READER_STATS_EN
    check_eq("s6_word_count", 32'(word_count), 32'd8);
    do_reset();
    check_eq("s6_word_count_rst", 32'(word_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width.
REQ-002 The block SHALL have parameter LENWIDTH, default 5, burst length width.
REQ-003 The block SHALL use reset reset, synchronous, active-low; clock clock.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 start  input  1  one-cycle burst request.
REQ-007 burst_len  input  LENWIDTH  number of words to drain; sampled with start.
REQ-008 busy  output  1  high while a burst is in progress.
REQ-009 done  output  1  one-cycle pulse when a burst completes.
REQ-010 fifo_empty  input  1  upstream FIFO has no data.
REQ-011 fifo_pop  output  1  pop strobe to FIFO, drives its read-advance input.
REQ-012 fifo_data  input  WIDTH  FIFO read data, valid the cycle after fifo_pop.
REQ-013 dout  output  WIDTH  registered output word.
REQ-014 dout_valid  output  1  dout holds a word.
REQ-015 dout_ready  input  1  downstream accepts dout.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD; it resets to IDLE.
REQ-017 In IDLE: start=1 with burst_len!=0 loads remaining=burst_len and moves to ISSUE next cycle.
REQ-018 In IDLE: start=1 with burst_len==0 does not leave IDLE and SHALL pulse done in the next cycle.
REQ-019 start while busy=1 SHALL be ignored; remaining is not reloaded.
REQ-020 In ISSUE: fifo_pop=1 combinationally iff fifo_empty=0, then move to WAIT; with fifo_empty=1 stay in ISSUE with fifo_pop=0.
REQ-021 fifo_pop SHALL be 0 in every state other than ISSUE; at most one pop per word.
REQ-022 In WAIT: fifo_data is registered into dout at the clock edge, and the FSM moves to HOLD.
REQ-023 In HOLD: dout_valid=1 and dout SHALL stay stable until dout_ready=1.
REQ-024 A handshake in HOLD (dout_valid and dout_ready) decrements remaining; if remaining was 1, move to IDLE and pulse done in the next cycle; otherwise move to ISSUE.
REQ-025 busy=1 in ISSUE, WAIT and HOLD; busy=0 in IDLE.
REQ-026 Maximum throughput SHALL be one word per 3 cycles; there SHALL be no pipelined pops.
REQ-027 remaining arithmetic SHALL be LENWIDTH bits, with no wrap, because 0 is never loaded.
REQ-028 Full burst_len range: 1 to 2^LENWIDTH-1 words.

Reset
REQ-029 With reset=0 at a clock edge: state=IDLE, remaining=0, dout=0, dout_valid=0, done=0, busy=0, fifo_pop=0.
REQ-030 Reset mid-burst SHALL abort the burst with no done pulse; a pop already issued is lost.

Configuration
REQ-031 Macro FIFO_READER_STATS_EN defined: add output word_count[15:0]; it counts every dout handshake, saturates at 16'hFFFF, and resets to 0.
REQ-032 Macro undefined: no word_count port or logic; all other behaviour is identical.

Structure
REQ-033 Package fifo_pkg SHALL hold the default WIDTH/LENWIDTH constants and the reader state typedef (IDLE, ISSUE, WAIT, HOLD).
REQ-034 No sub-module SHALL be used; the FSM, counter and output register are in one module.

Verification
REQ-035 Scenario 1: reset, start with burst_len=3, FIFO holds 16'hA1,16'hB2,16'hC3, dout_ready=1 -> three pops; dout sequence A1,B2,C3; one done pulse; busy low after done.
REQ-036 Scenario 2: burst_len=2, fifo_empty=1 for 5 cycles after start -> fifo_pop stays 0 and the FSM holds ISSUE; the first pop occurs in the cycle fifo_empty drops.
REQ-037 Scenario 3: burst_len=1, dout_ready=0 for 4 cycles in HOLD -> dout stable with dout_valid=1; done occurs 1 cycle after ready rises.
REQ-038 Scenario 4: start with burst_len=0 -> done pulses, busy stays 0, no pop.
REQ-039 Scenario 5: reset asserted in WAIT of a burst_len=4 burst -> all outputs reach reset values and no done pulse; a new start then runs normally.
REQ-040 Scenario 6 (STATS_EN): two bursts of 3 and 5 words -> word_count=8; a second start while busy is ignored.
